// File: rtl/pcm_mm_rr_sched_if.sv
// Bundle of the requester-side handshake and the pcm_mem_mm Avalon-MM port
// for pcm_mm_rr_sched. The scheduler takes the slave view; the requesters and
// the memory take the master view.
//
// Handshake: a requester raises req_valid[p] with req_write/req_addr/req_wdata
// and holds all of them stable until it sees req_ready[p] high for one cycle;
// valid may not be withdrawn before that. A read is answered later by a single
// rsp_valid[p] cycle with the data on the shared rsp_rdata.
interface pcm_mm_rr_sched_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic                  init;
  logic [3:0]            req_valid;
  logic [3:0]            req_write;
  logic [4*ADDR_W-1:0]   req_addr;
  logic [4*DATA_W-1:0]   req_wdata;
  logic [3:0]            req_ready;
  logic [3:0]            rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  clear_busy;
  logic [ADDR_W-1:0]     pcm_mem_mm_address;
  logic                  pcm_mem_mm_chipselect;
  logic                  pcm_mem_mm_clken;
  logic                  pcm_mem_mm_write;
  logic [DATA_W-1:0]     pcm_mem_mm_readdata;
  logic [DATA_W-1:0]     pcm_mem_mm_writedata;
  logic [1:0]            pcm_mem_mm_byteenable;

  modport master (
    output init, req_valid, req_write, req_addr, req_wdata, pcm_mem_mm_readdata,
    input  req_ready, rsp_valid, rsp_rdata, clear_busy,
    input  pcm_mem_mm_address, pcm_mem_mm_chipselect, pcm_mem_mm_clken,
    input  pcm_mem_mm_write, pcm_mem_mm_writedata, pcm_mem_mm_byteenable
  );

  modport slave (
    input  init, req_valid, req_write, req_addr, req_wdata, pcm_mem_mm_readdata,
    output req_ready, rsp_valid, rsp_rdata, clear_busy,
    output pcm_mem_mm_address, pcm_mem_mm_chipselect, pcm_mem_mm_clken,
    output pcm_mem_mm_write, pcm_mem_mm_writedata, pcm_mem_mm_byteenable
  );
endinterface

// File: rtl/pcm_mm_rr_sched.sv
// Round-robin scheduler sharing the single pcm_mem_mm Avalon-MM slave between
// four requesters, one transaction in flight at a time, fixed read latency.
// Optional init-triggered zero sweep of addresses 0..CLEAR_WORDS-1 is built
// only when the macro PCM_MM_CLEAR_EN is defined.
// o_dbg_state exposes the FSM state (0 IDLE, 1 ISSUE, 2 WAIT_RD, 3 RESP, 4 CLEAR).
module pcm_mm_rr_sched #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 2,
  parameter int CLEAR_WORDS  = 1024
) (
  input  logic             clk,
  input  logic             reset,
  pcm_mm_rr_sched_if.slave bus,
  output logic [2:0]       o_dbg_state
);

`ifdef PCM_MM_CLEAR_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT_RD = 3'd2, S_RESP = 3'd3, S_CLEAR = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT_RD = 3'd2, S_RESP = 3'd3
  } state_t;
`endif

  localparam logic [2:0]        LP_LAT_LAST = 3'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] LP_CLR_LAST = ADDR_W'(CLEAR_WORDS - 1);

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_last, w_last_nxt;
  logic [1:0]          r_gnt, w_gnt_nxt;
  logic [2:0]          r_lat_cnt, w_lat_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_write, w_write_nxt;
  logic                r_cs, w_cs_nxt;
  logic [3:0]          r_ready, w_ready_nxt;
  logic [3:0]          r_rsp_valid, w_rsp_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
`ifdef PCM_MM_CLEAR_EN
  logic                r_clear_pend, w_pend_nxt;
  logic                r_clear_busy, w_busy_nxt;
`else
  logic                w_unused_cfg;
  assign w_unused_cfg = bus.init | (|LP_CLR_LAST);
`endif

  // Round-robin pick: first valid port after the last grant, wrapping to it.
  logic [1:0] w_p1, w_p2, w_p3, w_pick;
  assign w_p1 = r_last + 2'd1;
  assign w_p2 = r_last + 2'd2;
  assign w_p3 = r_last + 2'd3;

  // Priority search last+1, last+2, last+3, last.
  always_comb begin
    w_pick = r_last;
    if (bus.req_valid[w_p1])      w_pick = w_p1;
    else if (bus.req_valid[w_p2]) w_pick = w_p2;
    else if (bus.req_valid[w_p3]) w_pick = w_p3;
  end

  // Next-state and next values of every registered output.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_gnt_nxt   = r_gnt;
    w_lat_nxt   = r_lat_cnt;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_write_nxt = r_write;
    w_cs_nxt    = r_cs;
    w_ready_nxt = 4'b0000;
    w_rsp_nxt   = 4'b0000;
    w_rdata_nxt = r_rdata;
`ifdef PCM_MM_CLEAR_EN
    w_pend_nxt  = r_clear_pend;
    w_busy_nxt  = r_clear_busy;
    if (bus.init && (r_state != S_CLEAR)) w_pend_nxt = 1'b1;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef PCM_MM_CLEAR_EN
        if (r_clear_pend || bus.init) begin
          w_state_nxt = S_CLEAR;
          w_cs_nxt    = 1'b1;
          w_write_nxt = 1'b1;
          w_addr_nxt  = '0;
          w_wdata_nxt = '0;
          w_busy_nxt  = 1'b1;
        end else
`endif
        if (|bus.req_valid) begin
          w_state_nxt = S_ISSUE;
          w_last_nxt  = w_pick;
          w_gnt_nxt   = w_pick;
          w_addr_nxt  = bus.req_addr[w_pick*ADDR_W +: ADDR_W];
          w_wdata_nxt = bus.req_wdata[w_pick*DATA_W +: DATA_W];
          w_write_nxt = bus.req_write[w_pick];
          w_cs_nxt    = 1'b1;
          w_ready_nxt = 4'b0001 << w_pick;
        end
      end
      S_ISSUE: begin
        w_cs_nxt    = 1'b0;
        w_write_nxt = 1'b0;
        w_lat_nxt   = LP_LAT_LAST;
        w_state_nxt = r_write ? S_IDLE : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (r_lat_cnt == 3'd0) begin
          w_rdata_nxt = bus.pcm_mem_mm_readdata;
          w_rsp_nxt   = 4'b0001 << r_gnt;
          w_state_nxt = S_RESP;
        end else begin
          w_lat_nxt = r_lat_cnt - 3'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
`ifdef PCM_MM_CLEAR_EN
      S_CLEAR: begin
        if (r_addr == LP_CLR_LAST) begin
          w_cs_nxt    = 1'b0;
          w_write_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_addr_nxt = r_addr + ADDR_W'(1);
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last       <= 2'd3;
      r_gnt        <= 2'd0;
      r_lat_cnt    <= 3'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_cs         <= 1'b0;
      r_ready      <= 4'b0000;
      r_rsp_valid  <= 4'b0000;
      r_rdata      <= '0;
`ifdef PCM_MM_CLEAR_EN
      r_clear_pend <= 1'b0;
      r_clear_busy <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_last       <= w_last_nxt;
      r_gnt        <= w_gnt_nxt;
      r_lat_cnt    <= w_lat_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_write      <= w_write_nxt;
      r_cs         <= w_cs_nxt;
      r_ready      <= w_ready_nxt;
      r_rsp_valid  <= w_rsp_nxt;
      r_rdata      <= w_rdata_nxt;
`ifdef PCM_MM_CLEAR_EN
      r_clear_pend <= w_pend_nxt;
      r_clear_busy <= w_busy_nxt;
`endif
    end
  end

  assign bus.req_ready             = r_ready;
  assign bus.rsp_valid             = r_rsp_valid;
  assign bus.rsp_rdata             = r_rdata;
`ifdef PCM_MM_CLEAR_EN
  assign bus.clear_busy            = r_clear_busy;
`else
  assign bus.clear_busy            = 1'b0;
`endif
  assign bus.pcm_mem_mm_address    = r_addr;
  assign bus.pcm_mem_mm_chipselect = r_cs;
  assign bus.pcm_mem_mm_clken      = 1'b1;
  assign bus.pcm_mem_mm_write      = r_write;
  assign bus.pcm_mem_mm_writedata  = r_wdata;
  assign bus.pcm_mem_mm_byteenable = 2'b11;
  assign o_dbg_state               = r_state;

endmodule

// File: doc/pcm_mm_rr_sched.md
# pcm_mm_rr_sched

Round-robin transaction scheduler that shares the single `pcm_mem_mm` Avalon-MM slave port between four requesters. Each requester uses a valid/ready request handshake and a one-cycle response strobe. The block issues at most one memory transaction at a time and tracks the slave's fixed read latency. It sits between the CPU-side request logic and the PCM memory port, and can optionally sweep-clear a memory range on `init`.

## Interface
- `ADDR_W`, 20, memory word address width
- `DATA_W`, 16, data width
- `READ_LATENCY`, 2, cycles from address cycle to valid `pcm_mem_mm_readdata` (legal 1..7)
- `CLEAR_WORDS`, 1024, words cleared from address 0 by the init sweep (legal 1..2^ADDR_W)

Ports:
- `clk` in 1 — single clock; all logic on rising edge
- `reset` in 1 — synchronous, active-high
- `init` in 1 — one-cycle clear request (used only with the macro)
- `req_valid` in 4 — request pending, one bit per port
- `req_write` in 4 — 1 = write, 0 = read
- `req_addr` in 4×ADDR_W — port p at bits [p*ADDR_W +: ADDR_W]
- `req_wdata` in 4×DATA_W — port p at bits [p*DATA_W +: DATA_W]
- `req_ready` out 4 — one-cycle accept strobe, one-hot
- `rsp_valid` out 4 — one-cycle read-data strobe, one-hot
- `rsp_rdata` out DATA_W — read data, shared by all ports
- `clear_busy` out 1 — init sweep in progress
- `pcm_mem_mm_address` out ADDR_W
- `pcm_mem_mm_chipselect` out 1
- `pcm_mem_mm_clken` out 1
- `pcm_mem_mm_write` out 1
- `pcm_mem_mm_readdata` in DATA_W
- `pcm_mem_mm_writedata` out DATA_W
- `pcm_mem_mm_byteenable` out 2

## Operation
- FSM states:
  - IDLE: if `clear_pend` is set, go to CLEAR. Otherwise, if any `req_valid` is set, grant the port picked by round-robin, register its addr/wdata/write into the memory output registers, and go to ISSUE.
  - ISSUE: one cycle with chipselect=1 and `req_ready[g]`=1. A write goes to IDLE; a read goes to WAIT_RD.
  - WAIT_RD: lasts READ_LATENCY cycles. Capture `pcm_mem_mm_readdata` into `rsp_rdata` on the last cycle, then go to RESP.
  - RESP: `rsp_valid[g]`=1 for one cycle, then go to IDLE.
  - CLEAR: see Configuration.
- Round-robin arbitration:
  - Pointer `last` (2 bits, reset 3) holds the most recently granted port.
  - Priority order is last+1, last+2, last+3, last, all mod 4.
  - `last` updates on every grant.
- Requester rules:
  - Hold `req_valid` and payload stable until `req_ready` is seen.
  - `req_valid` may not be dropped before it is accepted.
  - The payload is sampled in the IDLE grant cycle.
- Memory side:
  - chipselect is asserted only in ISSUE and CLEAR.
  - `pcm_mem_mm_write` is asserted only with chipselect.
  - clken is constant 1.
  - byteenable is constant 2'b11.
- Simultaneous events:
  - `init` arriving in a non-IDLE state sets `clear_pend`. The current transaction completes first, then the FSM enters CLEAR from IDLE.
  - Requests are never accepted while `clear_pend` or `clear_busy` is set.
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0
  - `clear_busy`=0, `clear_pend`=0
  - address=0, writedata=0, write=0, chipselect=0
  - `last`=3, FSM=IDLE
  - clken=1, byteenable=2'b11
- Reset mid-transaction: any in-flight read is abandoned and no `rsp_valid` is produced.

## Timing
- Write: grant in cycle T (IDLE), ISSUE and `req_ready` in T+1, IDLE in T+2. Occupancy is 2 cycles.
- Read:
  - Grant in T, ISSUE and address in T+1.
  - Readdata is valid in T+1+READ_LATENCY and captured at the end of that cycle.
  - `rsp_valid` is high in T+2+READ_LATENCY.
  - Occupancy is 3+READ_LATENCY cycles (5 at default).
- Back-to-back: the next grant is made in the cycle after ISSUE (write) or after RESP (read).
- Worst-case wait for any valid port: 3 other transactions.

## Configuration
- Macro `PCM_MM_CLEAR_EN`.
- Defined:
  - `init` sets `clear_pend`, and IDLE then enters CLEAR.
  - CLEAR writes 0 to addresses 0..CLEAR_WORDS-1, one per cycle, with chipselect=1 and write=1.
  - `clear_busy`=1 for exactly CLEAR_WORDS cycles, then the FSM returns to IDLE and `clear_pend` is cleared.
  - `init` during CLEAR is ignored.
- Not defined:
  - `init` is ignored and `clear_busy` is tied to 0.
  - No CLEAR state or address counter exists.

## Test plan
- Port 2 reads address 0x00010 (memory holds 0xBEEF), READ_LATENCY=2 -> `req_ready[2]` in cycle 1, `rsp_valid[2]` with `rsp_rdata`=0xBEEF in cycle 4, then IDLE.
- All four ports issue reads from reset -> grant order 0,1,2,3; each `rsp_valid` is 5 cycles after the previous one; every response carries the correct data.
- `last`=1, ports 0 and 1 valid -> port 0 granted first, then port 1.
- Port 3 writes 0x1234 to 0x00100, then port 0 reads 0x00100 -> write strobe with writedata 0x1234 occurs in a single cycle; the read returns 0x1234.
- `PCM_MM_CLEAR_EN`, CLEAR_WORDS=8, `init` pulse while port 1 read is in WAIT_RD -> read completes; `clear_busy` is high for 8 cycles writing 0 to addresses 0..7; a port 0 request held during this time gets `req_ready` only afterwards.
- `reset` asserted in WAIT_RD -> next cycle all outputs are at their reset values; no `rsp_valid` appears; the first grant after release goes to port 0.
